// File: rtl/icache_line_adapter.sv
// icache_line_adapter: fills one icache line with a single burst read and
// assembles the beats into a full line returned with a one-cycle response.
module icache_line_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CW = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  typedef enum logic [1:0] {IDLE, REQ, BURST, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [ADDR_WIDTH-1:0] bmem_addr_q, bmem_addr_d;
  logic                  bmem_read_q, bmem_read_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] dfp_rdata_q, dfp_rdata_d;
  logic                  dfp_resp_q, dfp_resp_d;
  logic                  beat_hit;

  assign beat_hit  = bmem_rvalid && (bmem_raddr == line_addr_q);
  assign dfp_rdata = dfp_rdata_q;
  assign dfp_resp  = dfp_resp_q;
  assign bmem_addr = bmem_addr_q;
  assign bmem_read = bmem_read_q;

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    bmem_addr_d = bmem_addr_q;
    bmem_read_d = bmem_read_q;
    beat_cnt_d  = beat_cnt_q;
    line_d      = line_q;
    dfp_rdata_d = dfp_rdata_q;
    dfp_resp_d  = 1'b0;
    case (state_q)
      IDLE: if (dfp_read) begin
        line_addr_d = dfp_addr & ~OFF_MASK;
        bmem_addr_d = dfp_addr & ~OFF_MASK;
        bmem_read_d = 1'b1;
        state_d     = REQ;
      end
      REQ: if (bmem_ready) begin
        bmem_read_d = 1'b0;
        bmem_addr_d = '0;
        beat_cnt_d  = '0;
        state_d     = BURST;
      end
      BURST: if (beat_hit) begin
        line_d[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
        beat_cnt_d = beat_cnt_q + 1'b1;
        // The last beat goes straight into the returned line so resp lands the next cycle
        if (beat_cnt_q == CW'(BEATS - 1)) begin
          dfp_rdata_d = line_d;
          dfp_resp_d  = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      bmem_addr_q <= '0;
      bmem_read_q <= 1'b0;
      beat_cnt_q  <= '0;
      line_q      <= '0;
      dfp_rdata_q <= '0;
      dfp_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      bmem_addr_q <= bmem_addr_d;
      bmem_read_q <= bmem_read_d;
      beat_cnt_q  <= beat_cnt_d;
      line_q      <= line_d;
      dfp_rdata_q <= dfp_rdata_d;
      dfp_resp_q  <= dfp_resp_d;
    end
  end
endmodule

// File: tb/tb_icache_line_adapter.sv
// tb_icache_line_adapter: table-driven line fills with a response scoreboard,
// plus hand sequences for reset mid-burst and back-to-back fills.
module tb_icache_line_adapter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  icache_line_adapter dut (
    .clk(clk), .rst_n(rst_n), .dfp_addr(dfp_addr), .dfp_read(dfp_read),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp), .bmem_addr(bmem_addr),
    .bmem_read(bmem_read), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       addr;
    logic [31:0]       exp_addr;
    logic [3:0][63:0]  b;
    int                rwait;
    int                gap;
    bit                stray;
    bit                idle_stray;
  } vec_t;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  vec_t         vt[7];
  logic [255:0] exp_q[$];
  logic [255:0] last_line;
  int           tests = 0;
  int           fails = 0;
  int           accepts = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (rst_n && bmem_read && bmem_ready) accepts++;

  always @(negedge clk) begin
    if (rst_n && dfp_resp) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 256'(dfp_resp), 256'(0));
      else chk("line_data", dfp_rdata, exp_q.pop_front());
    end
  end

  task automatic fill(input vec_t v);
    int acc0;
    acc0 = accepts;
    if (v.idle_stray) begin
      bmem_rvalid = 1'b1; bmem_raddr = v.exp_addr; bmem_rdata = JUNK;
      @(negedge clk);
      bmem_rvalid = 1'b0;
    end
    dfp_read = 1'b1;
    dfp_addr = v.addr;
    exp_q.push_back(v.b);
    @(negedge clk);
    dfp_addr = ~v.addr;
    chk("rdata_held", dfp_rdata, last_line);
    for (int i = 0; i <= v.rwait; i++) begin
      chk("req_read", 256'(bmem_read), 256'(1));
      chk("req_addr", 256'(bmem_addr), 256'(v.exp_addr));
      bmem_ready = (i == v.rwait);
      bmem_rvalid = 1'b1; bmem_raddr = v.exp_addr; bmem_rdata = JUNK;
      @(negedge clk);
    end
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b0;
    chk("read_drop", 256'(bmem_read), 256'(0));
    for (int b = 0; b < 4; b++) begin
      repeat (v.gap) @(negedge clk);
      if (v.stray) begin
        bmem_rvalid = 1'b1; bmem_raddr = v.exp_addr ^ 32'h20; bmem_rdata = JUNK;
        @(negedge clk);
      end
      chk("no_early_resp", 256'(dfp_resp), 256'(0));
      bmem_rvalid = 1'b1; bmem_raddr = v.exp_addr; bmem_rdata = v.b[b];
      @(negedge clk);
      bmem_rvalid = 1'b0;
    end
    chk("resp", 256'(dfp_resp), 256'(1));
    dfp_read = 1'b0;
    last_line = v.b;
    @(negedge clk);
    chk("resp_one_cycle", 256'(dfp_resp), 256'(0));
    chk("one_burst", 256'(accepts - acc0), 256'(1));
  endtask

  initial begin
    vt[0] = '{addr: 32'h1234_5678, exp_addr: 32'h1234_5660,
              b: {64'hA3A3_0000_0000_00A3, 64'hA2A2_0000_0000_00A2, 64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0},
              rwait: 0, gap: 0, stray: 0, idle_stray: 1};
    vt[1] = '{addr: 32'hDEAD_BEEF, exp_addr: 32'hDEAD_BEE0,
              b: {64'h3333_4444_5555_6666, 64'h2222_3333_4444_5555, 64'h1111_2222_3333_4444, 64'h0000_1111_2222_3333},
              rwait: 3, gap: 0, stray: 0, idle_stray: 1};
    vt[2] = '{addr: 32'h1234_5678, exp_addr: 32'h1234_5660,
              b: {64'hA3A3_0000_0000_00A3, 64'hA2A2_0000_0000_00A2, 64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0},
              rwait: 0, gap: 2, stray: 0, idle_stray: 1};
    vt[3] = '{addr: 32'h8000_003F, exp_addr: 32'h8000_0020,
              b: {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002, 64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000},
              rwait: 1, gap: 1, stray: 1, idle_stray: 1};
    vt[4] = '{addr: 32'h0000_0040, exp_addr: 32'h0000_0040,
              b: {64'h4040_0000_0000_0003, 64'h4040_0000_0000_0002, 64'h4040_0000_0000_0001, 64'h4040_0000_0000_0000},
              rwait: 0, gap: 0, stray: 0, idle_stray: 1};
    vt[5] = '{addr: 32'h0000_0100, exp_addr: 32'h0000_0100,
              b: {64'h0100_0000_0000_0013, 64'h0100_0000_0000_0012, 64'h0100_0000_0000_0011, 64'h0100_0000_0000_0010},
              rwait: 0, gap: 0, stray: 0, idle_stray: 0};
    vt[6] = '{addr: 32'h0000_0120, exp_addr: 32'h0000_0120,
              b: {64'h0120_0000_0000_0023, 64'h0120_0000_0000_0022, 64'h0120_0000_0000_0021, 64'h0120_0000_0000_0020},
              rwait: 0, gap: 0, stray: 0, idle_stray: 0};
    rst_n = 1'b0; dfp_addr = '0; dfp_read = 1'b0; bmem_ready = 1'b0;
    bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0; last_line = '0;
    repeat (2) @(negedge clk);
    chk("rst_bmem_read", 256'(bmem_read), 256'(0));
    chk("rst_bmem_addr", 256'(bmem_addr), 256'(0));
    chk("rst_dfp_resp", 256'(dfp_resp), 256'(0));
    chk("rst_dfp_rdata", dfp_rdata, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) fill(vt[i]);
    dfp_read = 1'b1; dfp_addr = 32'h0000_0200;
    @(negedge clk);
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0200; bmem_rdata = 64'h5555_0000;
    @(negedge clk);
    bmem_rdata = 64'h5555_0001;
    @(negedge clk);
    bmem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bmem_read", 256'(bmem_read), 256'(0));
    chk("abort_bmem_addr", 256'(bmem_addr), 256'(0));
    chk("abort_dfp_resp", 256'(dfp_resp), 256'(0));
    chk("abort_dfp_rdata", dfp_rdata, 256'(0));
    dfp_read = 1'b0;
    last_line = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bmem_rvalid = 1'b1; bmem_rdata = 64'h5555_0002;
    @(negedge clk);
    bmem_rdata = 64'h5555_0003;
    @(negedge clk);
    bmem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_beats_no_cmd", 256'(bmem_read), 256'(0));
    chk("late_beats_no_resp", 256'(dfp_resp), 256'(0));
    fill(vt[4]);
    fill(vt[5]);
    fill(vt[6]);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
